// File: rtl/tap_debouncer.sv
// rtl/tap_debouncer.sv - debounced, arbitrated one-hot tap pulses from raw mole-hole inputs
//
// Purpose: per-channel 2-flop synchronizer, counter debounce, rising-edge
// detect and lowest-index arbitration gated by enable.
//
// Ports:
//   clk          system clock, rising edge
//   clr          synchronous active-high reset
//   enable       round running; gates tap and multi_press only
//   raw_tap      asynchronous raw inputs, 1 = pressed
//   tap          one-hot single-cycle press pulse
//   tap_level    debounced level per channel
//   multi_press  single-cycle flag: two or more presses accepted together
module tap_debouncer #(
  parameter int N_TAPS          = 9,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              enable,
  input  logic [N_TAPS-1:0] raw_tap,
  output logic [N_TAPS-1:0] tap,
  output logic [N_TAPS-1:0] tap_level,
  output logic              multi_press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_TAPS-1:0] s1;
  logic [N_TAPS-1:0] raw_s;
  logic [N_TAPS-1:0] lvl_prev;
  logic [N_TAPS-1:0] rise;
  logic [N_TAPS-1:0] first_rise;
  logic              multi;
  logic              seen;
  logic [CNT_W-1:0]  cnt [N_TAPS];

  always_comb begin
    rise       = tap_level & ~lvl_prev;
    // Isolate the lowest set bit: two's complement trick.
    first_rise = rise & (~rise + N_TAPS'(1));
    seen       = 1'b0;
    multi      = 1'b0;
    for (int i = 0; i < N_TAPS; i++) begin
      multi = multi | (seen & rise[i]);
      seen  = seen | rise[i];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      s1          <= '0;
      raw_s       <= '0;
      tap_level   <= '0;
      lvl_prev    <= '0;
      tap         <= '0;
      multi_press <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1          <= raw_tap;
      raw_s       <= s1;
      // Tracks the level regardless of enable, so a rise seen while
      // disabled is consumed and never replayed later.
      lvl_prev    <= tap_level;
      tap         <= enable ? first_rise : '0;
      multi_press <= enable & multi;
      for (int i = 0; i < N_TAPS; i++) begin
        if (raw_s[i] == tap_level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          tap_level[i] <= raw_s[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

endmodule
